// File: rtl/bfly_pingpong_buf.sv
// Ping-pong frame buffer on the butterfly output side. Frames of DEPTH parallel
// complex vectors are captured into one bank while the other bank drains in
// write order over a valid/ready handshake.
module bfly_pingpong_buf #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IN_SIZE    = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          din_valid,
  input  logic [IN_SIZE*DATA_WIDTH-1:0] din_i,
  input  logic [IN_SIZE*DATA_WIDTH-1:0] din_q,
  input  logic                          dout_ready,
  output logic                          dout_valid,
  output logic [IN_SIZE*DATA_WIDTH-1:0] dout_i,
  output logic [IN_SIZE*DATA_WIDTH-1:0] dout_q,
  output logic                          dout_first,
  output logic                          dout_last,
  output logic [1:0]                    full_cnt,
  output logic                          ovf
);

  localparam int unsigned VecW = IN_SIZE * DATA_WIDTH;
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [VecW-1:0] bank_i_q [0:1][0:DEPTH-1];
  logic [VecW-1:0] bank_i_d [0:1][0:DEPTH-1];
  logic [VecW-1:0] bank_q_q [0:1][0:DEPTH-1];
  logic [VecW-1:0] bank_q_d [0:1][0:DEPTH-1];

  logic [1:0]      full_q, full_d;
  logic            wsel_q, wsel_d;
  logic            rsel_q, rsel_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic            ovf_q, ovf_d;

  logic wr_en;
  logic rd_en;

  // Handshake decode: a write needs a free target bank, a read needs a full one.
  // Both can never address the same bank on one edge.
  always_comb begin
    wr_en = din_valid & ~full_q[wsel_q];
    rd_en = full_q[rsel_q] & dout_ready;
  end

  // Next-state for pointers, bank flags, sticky overflow and storage.
  always_comb begin
    bank_i_d = bank_i_q;
    bank_q_d = bank_q_q;
    full_d   = full_q;
    wsel_d   = wsel_q;
    rsel_d   = rsel_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    ovf_d    = ovf_q | (din_valid & full_q[wsel_q]);

    if (rd_en) begin
      if (rptr_q == LastPtr) begin
        full_d[rsel_q] = 1'b0;
        rsel_d         = ~rsel_q;
        rptr_d         = '0;
      end else begin
        rptr_d = rptr_q + 1'b1;
      end
    end

    if (wr_en) begin
      bank_i_d[wsel_q][wptr_q] = din_i;
      bank_q_d[wsel_q][wptr_q] = din_q;
      if (wptr_q == LastPtr) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = ~wsel_q;
        wptr_d         = '0;
      end else begin
        wptr_d = wptr_q + 1'b1;
      end
    end
  end

  // State and storage registers; reset clears everything including storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < int'(DEPTH); e++) begin
          bank_i_q[b][e] <= '0;
          bank_q_q[b][e] <= '0;
        end
      end
      full_q <= '0;
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      bank_i_q <= bank_i_d;
      bank_q_q <= bank_q_d;
      full_q   <= full_d;
      wsel_q   <= wsel_d;
      rsel_q   <= rsel_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Read port is purely combinational from registered state.
  always_comb begin
    dout_valid = full_q[rsel_q];
    dout_i     = bank_i_q[rsel_q][rptr_q];
    dout_q     = bank_q_q[rsel_q][rptr_q];
    dout_first = dout_valid & (rptr_q == '0);
    dout_last  = dout_valid & (rptr_q == LastPtr);
    full_cnt   = 2'(full_q[0]) + 2'(full_q[1]);
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_bfly_pingpong_buf.sv
// Self-checking bench for bfly_pingpong_buf: a queue-based frame model checked
// every cycle, plus directed literal expectations.
module tb_bfly_pingpong_buf;

  localparam int DW    = 10;
  localparam int DEPTH = 16;
  localparam int NS    = 16;
  localparam int W     = DW * NS;

  logic         clk;
  logic         rstn;
  logic         din_valid;
  logic [W-1:0] din_i;
  logic [W-1:0] din_q;
  logic         dout_ready;
  logic         dout_valid;
  logic [W-1:0] dout_i;
  logic [W-1:0] dout_q;
  logic         dout_first;
  logic         dout_last;
  logic [1:0]   full_cnt;
  logic         ovf;

  bfly_pingpong_buf #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .IN_SIZE   (NS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .din_valid (din_valid),
    .din_i     (din_i),
    .din_q     (din_q),
    .dout_ready(dout_ready),
    .dout_valid(dout_valid),
    .dout_i    (dout_i),
    .dout_q    (dout_q),
    .dout_first(dout_first),
    .dout_last (dout_last),
    .full_cnt  (full_cnt),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] mk_i(input int f, input int k);
    logic [W-1:0] v;
    for (int j = 0; j < NS; j++) v[j*DW +: DW] = DW'(f * 256 + k * 16 + j);
    return v;
  endfunction

  function automatic logic [W-1:0] mk_q(input int f, input int k);
    logic [W-1:0] v;
    for (int j = 0; j < NS; j++) v[j*DW +: DW] = DW'((f * 256 + k * 16 + j) ^ 'h155);
    return v;
  endfunction

  function automatic logic [DW-1:0] lane(input logic [W-1:0] v, input int j);
    return v[j*DW +: DW];
  endfunction

  // Model: complete frames as one flat queue of vectors, plus the partial frame.
  logic [W-1:0] cq_i[$];
  logic [W-1:0] cq_q[$];
  logic [W-1:0] pq_i[$];
  logic [W-1:0] pq_q[$];
  int           ridx;
  bit           m_ovf;
  int           nfr;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cq_i.delete(); cq_q.delete(); pq_i.delete(); pq_q.delete();
      ridx  = 0;
      m_ovf = 0;
    end else begin
      // Banks occupied by complete frames, counted before this edge.
      nfr = (cq_i.size() + DEPTH - 1) / DEPTH;
      if (din_valid && nfr == 2) m_ovf = 1;
      if (cq_i.size() > 0 && dout_ready) begin
        void'(cq_i.pop_front());
        void'(cq_q.pop_front());
        ridx = (ridx == DEPTH - 1) ? 0 : ridx + 1;
      end
      if (din_valid && nfr < 2) begin
        pq_i.push_back(din_i);
        pq_q.push_back(din_q);
        if (pq_i.size() == DEPTH) begin
          foreach (pq_i[e]) begin
            cq_i.push_back(pq_i[e]);
            cq_q.push_back(pq_q[e]);
          end
          pq_i.delete(); pq_q.delete();
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  logic         e_valid;
  logic [1:0]   e_cnt;
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_valid", W'(dout_valid), '0);
      chk("rst_first", W'(dout_first), '0);
      chk("rst_last",  W'(dout_last),  '0);
      chk("rst_cnt",   W'(full_cnt),   '0);
      chk("rst_ovf",   W'(ovf),        '0);
      chk("rst_dout_i", dout_i, '0);
      chk("rst_dout_q", dout_q, '0);
    end else begin
      e_valid = cq_i.size() > 0;
      e_cnt   = 2'((cq_i.size() + DEPTH - 1) / DEPTH);
      chk("valid",    W'(dout_valid), W'(e_valid));
      chk("first",    W'(dout_first), W'(e_valid && ridx == 0));
      chk("last",     W'(dout_last),  W'(e_valid && ridx == DEPTH - 1));
      chk("full_cnt", W'(full_cnt),   W'(e_cnt));
      chk("ovf",      W'(ovf),        W'(m_ovf));
      if (e_valid) begin
        chk("dout_i", dout_i, cq_i[0]);
        chk("dout_q", dout_q, cq_q[0]);
      end
    end
  end

  // Transfer counter and full_cnt peak tracker for directed checks.
  int xfers = 0;
  always @(posedge clk) if (rstn && dout_valid && dout_ready) xfers++;

  bit track = 0;
  int peak  = 0;
  always @(negedge clk) begin
    if (!track) peak = 0;
    else if (int'(full_cnt) > peak) peak = int'(full_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vecs(input int f, input int n);
    for (int k = 0; k < n; k++) begin
      din_valid = 1'b1;
      din_i     = mk_i(f, k);
      din_q     = mk_q(f, k);
      tick();
    end
    din_valid = 1'b0;
  endtask

  int x0;

  initial begin
    rstn       = 1'b0;
    din_valid  = 1'b0;
    din_i      = '0;
    din_q      = '0;
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("init_valid", W'(dout_valid), '0);
    chk("init_cnt",   W'(full_cnt),   '0);

    // Single frame, ready high: output appears the cycle after the last write.
    dout_ready = 1'b1;
    write_vecs(0, 16);
    @(negedge clk);
    chk("f0_valid",  W'(dout_valid), W'(1));
    chk("f0_first",  W'(dout_first), W'(1));
    chk("f0_i_l3",   W'(lane(dout_i, 3)), W'(3));
    chk("f0_q_l0",   W'(lane(dout_q, 0)), W'('h155));
    repeat (15) tick();
    @(negedge clk);
    chk("f0_last",   W'(dout_last), W'(1));
    chk("f0_i15_l2", W'(lane(dout_i, 2)), W'(242));
    tick();
    @(negedge clk);
    chk("f0_done",   W'(dout_valid), '0);

    // Back-to-back frames; B completes on the same edge A drains its last vector.
    track = 1;
    write_vecs(1, 16);
    write_vecs(2, 16);
    @(negedge clk);
    chk("ab_cnt",    W'(full_cnt), W'(1));
    chk("ab_first",  W'(dout_first), W'(1));
    chk("ab_b0_l0",  W'(lane(dout_i, 0)), W'(512));
    repeat (17) tick();
    @(negedge clk);
    chk("ab_peak",   W'(peak), W'(1));
    chk("ab_ovf",    W'(ovf), '0);
    track = 0;

    // Three frames with ready low: third frame dropped, then drain two.
    dout_ready = 1'b0;
    write_vecs(3, 16);
    write_vecs(4, 16);
    write_vecs(5, 16);
    @(negedge clk);
    chk("ov_cnt",    W'(full_cnt), W'(2));
    chk("ov_ovf",    W'(ovf), W'(1));
    dout_ready = 1'b1;
    repeat (33) tick();
    @(negedge clk);
    chk("ov_drain",  W'(full_cnt), '0);

    // Toggling ready during a drain: exactly one frame's worth of transfers.
    dout_ready = 1'b0;
    write_vecs(6, 16);
    x0 = xfers;
    for (int i = 0; i < 40; i++) begin
      dout_ready = (i % 2 == 0);
      tick();
    end
    dout_ready = 1'b1;
    @(negedge clk);
    chk("tg_xfers",  W'(xfers - x0), W'(16));
    chk("tg_cnt",    W'(full_cnt), '0);

    // Async reset mid-write and mid-drain.
    dout_ready = 1'b0;
    write_vecs(7, 16);
    dout_ready = 1'b1;
    write_vecs(9, 8);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("ar_valid",  W'(dout_valid), '0);
    chk("ar_cnt",    W'(full_cnt), '0);
    chk("ar_ovf",    W'(ovf), '0);
    chk("ar_dout_i", dout_i, '0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("ar_idle",   W'(dout_valid), '0);
    write_vecs(10, 16);
    @(negedge clk);
    chk("ar_first",  W'(dout_first), W'(1));
    chk("ar_i_l1",   W'(lane(dout_i, 1)), W'(513));
    repeat (20) tick();
    @(negedge clk);
    chk("ar_end",    W'(full_cnt), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
